// File: rtl/pattern_checker_if.sv
// Handshake bundle between the pattern checker and its driver (pattern source, keypad, game manager).
interface pattern_checker_if #(
  parameter int MAX_LEN = 16
);
  logic                   start;
  logic [3*MAX_LEN-1:0]   patterns;
  logic [4:0]             len;
  logic                   key_valid;
  logic [2:0]             key_code;
  logic                   busy;
  logic                   key_hit;
  logic [4:0]             progress;
  logic                   done;
  logic                   pass;
  logic                   fail;
  logic                   timeout;

  modport master (
    output start, patterns, len, key_valid, key_code,
    input  busy, key_hit, progress, done, pass, fail, timeout
  );

  modport slave (
    input  start, patterns, len, key_valid, key_code,
    output busy, key_hit, progress, done, pass, fail, timeout
  );
endinterface

// File: rtl/pattern_checker.sv
// Checks keypad entries one at a time against a latched pattern sequence; one-cycle key-to-result latency.
// Optional idle-key watchdog enabled by defining INPUT_TIMEOUT_EN.
module pattern_checker #(
  parameter int MAX_LEN        = 16,
  parameter int TIMEOUT_CYCLES = 5_000_000
) (
  input logic              clk_1,
  input logic              rst,
  pattern_checker_if.slave bus
);
  typedef enum logic {IDLE, WAIT_KEY} state_t;

  localparam logic [5:0] MAX_LEN_W = 6'(MAX_LEN);

  // len is a 5-bit port, so a longer sequence could never be addressed.
  if (MAX_LEN < 1 || MAX_LEN > 31 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("pattern_checker: MAX_LEN must be 1..31 and TIMEOUT_CYCLES >= 1");
  end

  state_t               state_q;
  logic [3*MAX_LEN-1:0] patterns_q;
  logic [4:0]           len_q;
  logic [4:0]           progress_q;
  logic                 busy_q;
  logic                 key_hit_q;
  logic                 done_q;
  logic                 pass_q;
  logic                 fail_q;

  logic [4:0]           len_d;
  logic [2:0]           exp_code;
  logic                 last_entry;

`ifdef INPUT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0]        idle_cnt_q;
  logic                 timeout_q;
`endif

  always_comb begin
    len_d = bus.len;
    if (bus.len == 5'd0) begin
      len_d = 5'd1;
    end else if ({1'b0, bus.len} > MAX_LEN_W) begin
      len_d = MAX_LEN_W[4:0];
    end
  end

  assign exp_code   = patterns_q[3*int'(progress_q) +: 3];
  assign last_entry = (progress_q + 5'd1) == len_q;

  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      patterns_q <= '0;
      len_q      <= 5'd1;
      progress_q <= 5'd0;
      busy_q     <= 1'b0;
      key_hit_q  <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
`ifdef INPUT_TIMEOUT_EN
      idle_cnt_q <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      key_hit_q <= 1'b0;
      done_q    <= 1'b0;
      // start outranks any key in the same cycle, including a restart mid-check.
      if (bus.start) begin
        state_q    <= WAIT_KEY;
        patterns_q <= bus.patterns;
        len_q      <= len_d;
        progress_q <= 5'd0;
        busy_q     <= 1'b1;
        pass_q     <= 1'b0;
        fail_q     <= 1'b0;
`ifdef INPUT_TIMEOUT_EN
        idle_cnt_q <= '0;
        timeout_q  <= 1'b0;
`endif
      end else if (state_q == WAIT_KEY) begin
        if (bus.key_valid) begin
`ifdef INPUT_TIMEOUT_EN
          idle_cnt_q <= '0;
`endif
          if (bus.key_code == exp_code) begin
            key_hit_q  <= 1'b1;
            progress_q <= progress_q + 5'd1;
            if (last_entry) begin
              done_q  <= 1'b1;
              pass_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end else begin
            done_q  <= 1'b1;
            fail_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
`ifdef INPUT_TIMEOUT_EN
        else if (idle_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          done_q    <= 1'b1;
          fail_q    <= 1'b1;
          timeout_q <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end else begin
          idle_cnt_q <= idle_cnt_q + TW'(1);
        end
`endif
      end
    end
  end

  assign bus.busy     = busy_q;
  assign bus.key_hit  = key_hit_q;
  assign bus.progress = progress_q;
  assign bus.done     = done_q;
  assign bus.pass     = pass_q;
  assign bus.fail     = fail_q;
`ifdef INPUT_TIMEOUT_EN
  assign bus.timeout  = timeout_q;
`else
  assign bus.timeout  = 1'b0;
`endif
endmodule
